multdiv_ctrl: RTL and testbench

Sequencer that sits directly upstream of the iterative divider and the iterative multiplier. It latches operands on a start pulse and drives the shared iteration count. It then captures the datapath outputs on the completion cycle and presents a held result with a one-cycle ready pulse. It is the only block that generates the datapath `count` input, including the count==0 load cycle that the divider relies on.

---
 rtl/multdiv_pkg.sv | 16 +
 rtl/op_counter.sv | 27 ++
 rtl/multdiv_ctrl.sv | 88 ++++++++
 tb/tb_multdiv_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/multdiv_pkg.sv
// Shared types and defaults for the multiply/divide sequencer.
// State encoding is fixed because downstream debug taps decode it.
package multdiv_pkg;

  localparam int DEF_WIDTH       = 32;
  localparam int DEF_DIV_CYCLES  = 33;
  localparam int DEF_MULT_CYCLES = 17;
  localparam int CNT_W           = 6;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MULT = 2'b01,
    DIV  = 2'b10
  } state_t;

endpackage

// File: rtl/op_counter.sv
// Iteration counter: 6-bit with sync clear and enable, zero-extended to 32 bits.
// Clear has priority over enable so a restart always lands on the load cycle.
module op_counter
  import multdiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  output logic [31:0] count
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign count = {{(32 - CNT_W){1'b0}}, cnt};

endmodule

// File: rtl/multdiv_ctrl.sv
// Sequencer for the iterative multiplier/divider: latches operands, drives count,
// captures the datapath outputs on the final count and pulses data_resultRDY once.
module multdiv_ctrl
  import multdiv_pkg::*;
#(
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES,
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int WIDTH       = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic [31:0]      count,
  input  logic [WIDTH-1:0] mult_result,
  input  logic             mult_ovf,
  input  logic [WIDTH-1:0] div_quotient,
  input  logic             div_exception,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  state_t state, state_d;
  logic   start, done_mult, done_div, done;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // A start always wins over completion for the next state; the completion
  // capture still happens in the datapath registers on that same edge.
  always_comb begin
    start     = ctrl_MULT | ctrl_DIV;
    done_mult = (state == MULT) && (count == 32'(MULT_CYCLES));
    done_div  = (state == DIV)  && (count == 32'(DIV_CYCLES));
    done      = done_mult | done_div;
    state_d   = state;
    if (start) begin
      state_d = ctrl_MULT ? MULT : DIV;
    end else if (done) begin
      state_d = IDLE;
    end
  end

  op_counter u_op_counter (
    .clk   (clk),
    .rst_n (reset_n),
    .clr   (start | done),
    .en    (state != IDLE),
    .count (count)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_a           <= '0;
      op_b           <= '0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else begin
      if (start) begin
        op_a <= data_operandA;
        op_b <= data_operandB;
      end
      data_resultRDY <= done;
      if (done_div) begin
        data_result    <= div_quotient;
        data_exception <= div_exception;
      end else if (done_mult) begin
        data_result    <= mult_result;
        data_exception <= mult_ovf;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Directed bench for multdiv_ctrl with a count-aware datapath model that only
// produces valid outputs on the final count, so mistimed captures show up.
module tb_multdiv_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        ctrl_MULT = 1'b0, ctrl_DIV = 1'b0;
  logic [31:0] data_operandA = '0, data_operandB = '0;
  logic [31:0] op_a, op_b, count;
  logic [31:0] mult_result, div_quotient, data_result;
  logic        mult_ovf, div_exception, data_exception, data_resultRDY, busy;

  int n_checks = 0;
  int n_pass   = 0;

  multdiv_ctrl dut (
    .clk(clk), .reset_n(reset_n), .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
    .data_operandA(data_operandA), .data_operandB(data_operandB),
    .op_a(op_a), .op_b(op_b), .count(count),
    .mult_result(mult_result), .mult_ovf(mult_ovf),
    .div_quotient(div_quotient), .div_exception(div_exception),
    .data_result(data_result), .data_exception(data_exception),
    .data_resultRDY(data_resultRDY), .busy(busy)
  );

  always #5 clk = ~clk;

  always_comb begin
    mult_result   = (count == 32'd17) ? op_a * op_b : 32'h0BAD0BAD;
    mult_ovf      = (count != 32'd17);
    div_exception = (count != 32'd33) || (op_b == 32'd0);
    if (count != 32'd33)     div_quotient = 32'hDEADBEEF;
    else if (op_b == 32'd0)  div_quotient = 32'd0;
    else                     div_quotient = 32'($signed(op_a) / $signed(op_b));
  end

  task automatic start_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    ctrl_MULT = m; ctrl_DIV = d; data_operandA = a; data_operandB = b;
  endtask

  // Runs from the start edge until RDY; returns latency in edges after the start edge.
  task automatic wait_rdy(output int lat, output int seq_err, output logic [31:0] a_mid,
                          output logic [31:0] b_mid, output logic rdy0, output logic [31:0] res0);
    int edges = 0;
    lat = -1; seq_err = 0; a_mid = '0; b_mid = '0; rdy0 = 1'b0; res0 = '0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); edges++;
      @(negedge clk);
      if (edges == 1) begin
        rdy0 = data_resultRDY; res0 = data_result;
        ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
        data_operandA = 32'hA5A5A5A5; data_operandB = 32'h5A5A5A5A;
      end
      if (edges == 10) begin a_mid = op_a; b_mid = op_b; end
      if (data_resultRDY && edges > 1) begin lat = edges - 1; break; end
      if (count !== 32'(edges - 1)) seq_err++;
    end
  endtask

  task automatic test_reset;
    #1 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (count !== 32'd0) $display("FAIL reset_count got %h exp 0", count); else n_pass++;
    n_checks++; if ({op_a, op_b, data_result} !== 96'd0) $display("FAIL reset_regs got %h/%h/%h exp 0", op_a, op_b, data_result); else n_pass++;
    n_checks++; if ({data_exception, data_resultRDY, busy} !== 3'b000) $display("FAIL reset_flags got %b exp 000", {data_exception, data_resultRDY, busy}); else n_pass++;
    reset_n = 1'b1;
  endtask

  task automatic test_div_basic;
    int lat, se; logic [31:0] am, bm, r0; logic k0;
    start_op(1'b0, 1'b1, 32'd100, 32'd7);
    wait_rdy(lat, se, am, bm, k0, r0);
    n_checks++; if (lat !== 34) $display("FAIL div_latency got %0d exp 34", lat); else n_pass++;
    n_checks++; if (se !== 0) $display("FAIL div_count_seq got %0d errors exp 0", se); else n_pass++;
    n_checks++; if ({am, bm} !== {32'd100, 32'd7}) $display("FAIL div_op_hold got %h/%h exp 100/7", am, bm); else n_pass++;
    n_checks++; if (data_result !== 32'd14) $display("FAIL div_result got %h exp %h", data_result, 32'd14); else n_pass++;
    n_checks++; if (data_exception !== 1'b0) $display("FAIL div_exc got %b exp 0", data_exception); else n_pass++;
    n_checks++; if ({busy, count} !== 33'd0) $display("FAIL div_idle got busy %b count %0d exp 0/0", busy, count); else n_pass++;
    @(negedge clk);
    n_checks++; if (data_resultRDY !== 1'b0) $display("FAIL div_rdy_pulse got %b exp 0", data_resultRDY); else n_pass++;
    n_checks++; if (data_result !== 32'd14) $display("FAIL div_result_hold got %h exp %h", data_result, 32'd14); else n_pass++;
  endtask

  task automatic test_div_neg;
    int lat, se; logic [31:0] am, bm, r0; logic k0;
    start_op(1'b0, 1'b1, 32'hFFFFFF9C, 32'd7);
    wait_rdy(lat, se, am, bm, k0, r0);
    n_checks++; if (lat !== 34) $display("FAIL divneg_latency got %0d exp 34", lat); else n_pass++;
    n_checks++; if (data_result !== 32'hFFFFFFF2) $display("FAIL divneg_result got %h exp fffffff2", data_result); else n_pass++;
    n_checks++; if (data_exception !== 1'b0) $display("FAIL divneg_exc got %b exp 0", data_exception); else n_pass++;
  endtask

  task automatic test_div_zero;
    int lat, se; logic [31:0] am, bm, r0; logic k0;
    start_op(1'b0, 1'b1, 32'd55, 32'd0);
    wait_rdy(lat, se, am, bm, k0, r0);
    n_checks++; if (lat !== 34) $display("FAIL divzero_latency got %0d exp 34", lat); else n_pass++;
    n_checks++; if (data_result !== 32'd0) $display("FAIL divzero_result got %h exp 0", data_result); else n_pass++;
    n_checks++; if (data_exception !== 1'b1) $display("FAIL divzero_exc got %b exp 1", data_exception); else n_pass++;
  endtask

  task automatic test_mult_priority;
    int lat, se; logic [31:0] am, bm, r0; logic k0;
    start_op(1'b1, 1'b1, 32'd3, 32'hFFFFFFFB);
    wait_rdy(lat, se, am, bm, k0, r0);
    n_checks++; if (lat !== 18) $display("FAIL mult_latency got %0d exp 18", lat); else n_pass++;
    n_checks++; if (se !== 0) $display("FAIL mult_count_seq got %0d errors exp 0", se); else n_pass++;
    n_checks++; if (bm !== 32'hFFFFFFFB) $display("FAIL mult_op_hold got %h exp fffffffb", bm); else n_pass++;
    n_checks++; if (data_result !== 32'hFFFFFFF1) $display("FAIL mult_result got %h exp fffffff1", data_result); else n_pass++;
    n_checks++; if (data_exception !== 1'b0) $display("FAIL mult_ovf got %b exp 0", data_exception); else n_pass++;
  endtask

  task automatic test_restart;
    int lat, se; logic [31:0] am, bm, r0; logic k0;
    logic seen = 1'b0;
    start_op(1'b0, 1'b1, 32'd100, 32'd7);
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); @(negedge clk);
      if (i == 0) begin ctrl_DIV = 1'b0; data_operandA = 32'd1; data_operandB = 32'd1; end
      if (data_resultRDY) seen = 1'b1;
      if (count == 32'd10) break;
    end
    n_checks++; if (count !== 32'd10) $display("FAIL restart_reach10 got %0d exp 10", count); else n_pass++;
    n_checks++; if (data_result !== 32'hFFFFFFF1) $display("FAIL restart_result_kept got %h exp fffffff1", data_result); else n_pass++;
    ctrl_DIV = 1'b1; data_operandA = 32'd81; data_operandB = 32'd9;
    wait_rdy(lat, se, am, bm, k0, r0);
    n_checks++; if ({seen, k0} !== 2'b00) $display("FAIL restart_no_rdy got %b exp 00", {seen, k0}); else n_pass++;
    n_checks++; if (lat !== 34) $display("FAIL restart_latency got %0d exp 34", lat); else n_pass++;
    n_checks++; if (am !== 32'd81) $display("FAIL restart_op_a got %h exp %h", am, 32'd81); else n_pass++;
    n_checks++; if (data_result !== 32'd9) $display("FAIL restart_result got %h exp 9", data_result); else n_pass++;
  endtask

  task automatic test_back_to_back;
    int lat, se; logic [31:0] am, bm, r0; logic k0;
    start_op(1'b1, 1'b0, 32'd6, 32'd7);
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); @(negedge clk);
      if (i == 0) ctrl_MULT = 1'b0;
      if (count == 32'd17) break;
    end
    ctrl_DIV = 1'b1; data_operandA = 32'd100; data_operandB = 32'd7;
    wait_rdy(lat, se, am, bm, k0, r0);
    n_checks++; if (k0 !== 1'b1) $display("FAIL b2b_mult_rdy got %b exp 1", k0); else n_pass++;
    n_checks++; if (r0 !== 32'd42) $display("FAIL b2b_mult_result got %h exp %h", r0, 32'd42); else n_pass++;
    n_checks++; if (se !== 0) $display("FAIL b2b_count_seq got %0d errors exp 0", se); else n_pass++;
    n_checks++; if (lat !== 34) $display("FAIL b2b_div_latency got %0d exp 34", lat); else n_pass++;
    n_checks++; if (data_result !== 32'd14) $display("FAIL b2b_div_result got %h exp %h", data_result, 32'd14); else n_pass++;
  endtask

  task automatic test_reset_midop;
    logic seen = 1'b0;
    start_op(1'b0, 1'b1, 32'd100, 32'd7);
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); @(negedge clk);
      if (i == 0) ctrl_DIV = 1'b0;
      if (count == 32'd20) break;
    end
    n_checks++; if (count !== 32'd20) $display("FAIL rstmid_reach20 got %0d exp 20", count); else n_pass++;
    reset_n = 1'b0;
    #1;
    n_checks++; if ({count, op_a, op_b, data_result} !== 128'd0) $display("FAIL rstmid_regs got %h/%h/%h/%h exp 0", count, op_a, op_b, data_result); else n_pass++;
    n_checks++; if ({data_exception, data_resultRDY, busy} !== 3'b000) $display("FAIL rstmid_flags got %b exp 000", {data_exception, data_resultRDY, busy}); else n_pass++;
    @(negedge clk); reset_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (data_resultRDY) seen = 1'b1;
    end
    n_checks++; if (seen !== 1'b0) $display("FAIL rstmid_no_rdy got %b exp 0", seen); else n_pass++;
    n_checks++; if ({busy, count, data_result} !== 65'd0) $display("FAIL rstmid_after got %b/%h/%h exp 0", busy, count, data_result); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_div_basic();
    test_div_neg();
    test_div_zero();
    test_mult_priority();
    test_restart();
    test_back_to_back();
    test_reset_midop();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
